cart_mem_server: RTL

CART_MEM_SERVER -- requirements
Module: cart_mem_server

---
 rtl/cart_mem_server.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/cart_mem_server.sv
// Purpose: arbitrates cartridge ROM fetches and cartridge RAM reads/writes onto one SDRAM req/ack port.
// Latency: sd_req rises the cycle after a request is selected; data is registered the cycle after sd_ack.
// Backpressure: one access at a time; requests wait in IDLE, and a single write edge is latched while busy.
module cart_mem_server #(
    parameter logic [19:0] ROM_BASE = 20'h00000,
    parameter logic [19:0] RAM_BASE = 20'h80000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [18:0] rom_a,
    input  logic        rom_read,
    output logic [7:0]  rom_do,
    input  logic [17:0] cartram_addr,
    input  logic        cartram_wr,
    input  logic        cartram_rd,
    input  logic [7:0]  cartram_wrdata,
    output logic [7:0]  cartram_data,
    output logic [19:0] sd_addr,
    output logic        sd_req,
    output logic        sd_we,
    output logic [7:0]  sd_wdata,
    input  logic        sd_ack,
    input  logic [7:0]  sd_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ROM_RD, RAM_RD, RAM_WR} state_t;

    state_t      state_q, state_d;
    logic        sd_req_q, sd_req_d;
    logic        sd_we_q, sd_we_d;
    logic [19:0] sd_addr_q, sd_addr_d;
    logic [7:0]  sd_wdata_q, sd_wdata_d;
    logic [7:0]  rom_do_q, rom_do_d;
    logic [7:0]  ram_do_q, ram_do_d;
    logic        rom_valid_q, rom_valid_d;
    logic        ram_valid_q, ram_valid_d;
    logic [18:0] last_rom_a_q, last_rom_a_d;
    logic [17:0] last_ram_a_q, last_ram_a_d;
    logic        wr_pending_q, wr_pending_d;
    logic [17:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [18:0] cap_a_q, cap_a_d;
    logic        prev_wr_q;
    logic [17:0] prev_ram_a_q;

    logic        wr_event;
    logic        ram_rd_need;
    logic        rom_need;
    logic [17:0] wr_sel_a;
    logic [7:0]  wr_sel_d;

    // A write is a rising edge of cartram_wr, or an address change while it stays high.
    assign wr_event    = cartram_wr & (~prev_wr_q | (cartram_addr != prev_ram_a_q));
    assign ram_rd_need = cartram_rd & (~ram_valid_q | (cartram_addr != last_ram_a_q));
    assign rom_need    = rom_read & (~rom_valid_q | (rom_a != last_rom_a_q));
    // A fresh edge in IDLE is serviced directly; otherwise the latched write is used.
    assign wr_sel_a    = wr_event ? cartram_addr : wr_addr_q;
    assign wr_sel_d    = wr_event ? cartram_wrdata : wr_data_q;

    assign rom_do       = rom_do_q;
    assign cartram_data = ram_do_q;
    assign sd_addr      = sd_addr_q;
    assign sd_req       = sd_req_q;
    assign sd_we        = sd_we_q;
    assign sd_wdata     = sd_wdata_q;
    assign busy         = (state_q != IDLE);

    // Next-state, request launch and completion bookkeeping.
    always_comb begin
        state_d      = state_q;
        sd_req_d     = sd_req_q;
        sd_we_d      = sd_we_q;
        sd_addr_d    = sd_addr_q;
        sd_wdata_d   = sd_wdata_q;
        rom_do_d     = rom_do_q;
        ram_do_d     = ram_do_q;
        rom_valid_d  = rom_valid_q;
        ram_valid_d  = ram_valid_q;
        last_rom_a_d = last_rom_a_q;
        last_ram_a_d = last_ram_a_q;
        wr_pending_d = wr_pending_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cap_a_d      = cap_a_q;

        // Write edges during an access are latched; a newer one replaces an older one.
        if (wr_event) begin
            wr_pending_d = 1'b1;
            wr_addr_d    = cartram_addr;
            wr_data_d    = cartram_wrdata;
        end

        case (state_q)
            IDLE: begin
                if (wr_event || wr_pending_q) begin
                    state_d      = RAM_WR;
                    sd_req_d     = 1'b1;
                    sd_we_d      = 1'b1;
                    sd_addr_d    = RAM_BASE + {2'b00, wr_sel_a};
                    sd_wdata_d   = wr_sel_d;
                    cap_a_d      = {1'b0, wr_sel_a};
                    wr_pending_d = 1'b0;
                end else if (ram_rd_need) begin
                    state_d   = RAM_RD;
                    sd_req_d  = 1'b1;
                    sd_we_d   = 1'b0;
                    sd_addr_d = RAM_BASE + {2'b00, cartram_addr};
                    cap_a_d   = {1'b0, cartram_addr};
                end else if (rom_need) begin
                    state_d   = ROM_RD;
                    sd_req_d  = 1'b1;
                    sd_we_d   = 1'b0;
                    sd_addr_d = ROM_BASE + {1'b0, rom_a};
                    cap_a_d   = rom_a;
                end
            end
            ROM_RD: begin
                if (sd_ack) begin
                    state_d      = IDLE;
                    sd_req_d     = 1'b0;
                    rom_do_d     = sd_rdata;
                    last_rom_a_d = cap_a_q;
                    rom_valid_d  = 1'b1;
                end
            end
            RAM_RD: begin
                if (sd_ack) begin
                    state_d      = IDLE;
                    sd_req_d     = 1'b0;
                    ram_do_d     = sd_rdata;
                    last_ram_a_d = cap_a_q[17:0];
                    ram_valid_d  = 1'b1;
                end
            end
            RAM_WR: begin
                // Write-through: the written byte becomes the cached RAM data.
                if (sd_ack) begin
                    state_d      = IDLE;
                    sd_req_d     = 1'b0;
                    ram_do_d     = sd_wdata_q;
                    last_ram_a_d = cap_a_q[17:0];
                    ram_valid_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset forces outputs immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sd_req_q     <= 1'b0;
            sd_we_q      <= 1'b0;
            sd_addr_q    <= 20'h0;
            sd_wdata_q   <= 8'h0;
            rom_do_q     <= 8'hFF;
            ram_do_q     <= 8'hFF;
            rom_valid_q  <= 1'b0;
            ram_valid_q  <= 1'b0;
            last_rom_a_q <= 19'h0;
            last_ram_a_q <= 18'h0;
            wr_pending_q <= 1'b0;
            wr_addr_q    <= 18'h0;
            wr_data_q    <= 8'h0;
            cap_a_q      <= 19'h0;
            prev_wr_q    <= 1'b0;
            prev_ram_a_q <= 18'h0;
        end else begin
            state_q      <= state_d;
            sd_req_q     <= sd_req_d;
            sd_we_q      <= sd_we_d;
            sd_addr_q    <= sd_addr_d;
            sd_wdata_q   <= sd_wdata_d;
            rom_do_q     <= rom_do_d;
            ram_do_q     <= ram_do_d;
            rom_valid_q  <= rom_valid_d;
            ram_valid_q  <= ram_valid_d;
            last_rom_a_q <= last_rom_a_d;
            last_ram_a_q <= last_ram_a_d;
            wr_pending_q <= wr_pending_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cap_a_q      <= cap_a_d;
            prev_wr_q    <= cartram_wr;
            prev_ram_a_q <= cartram_addr;
        end
    end

endmodule
